// File: rtl/debug_arb_pkg.sv
// Shared types and constants for the debug register port arbiter.
// The optional write-protect feature is enabled with DEBUG_ARB_WPROT_EN.
package debug_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ   = 2;
  localparam int DEF_NB_ADDR = 7;
  localparam int DEF_NB_DATA = 8;

  // Control register window that only the SPI slave (requester 0) may write.
  localparam int WPROT_LO = 'h10;
  localparam int WPROT_HI = 'h1F;

  function automatic logic in_wprot(input int addr);
    return (addr >= WPROT_LO) && (addr <= WPROT_HI);
  endfunction

endpackage

// File: rtl/debug_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module debug_rr_arbiter #(
  parameter int N_REQ = 2
)(
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);
  localparam int IDXW = $clog2(N_REQ);

  int idx;

  // Scan from the farthest offset back toward ptr so the nearest request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    any_req   = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/debug_bus_arbiter.sv
// Round-robin sharing of the debug register port, one access per 3 cycles.
// Define DEBUG_ARB_WPROT_EN to block non-SPI writes to the control window.
module debug_bus_arbiter
  import debug_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int NB_ADDR = DEF_NB_ADDR,
  parameter int NB_DATA = DEF_NB_DATA
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*NB_ADDR-1:0]   req_addr,
  input  logic [N_REQ*NB_DATA-1:0]   req_wdata,
  output logic [N_REQ-1:0]           rsp_ack,
  output logic [NB_DATA-1:0]         rsp_rdata,
  output logic [NB_ADDR-1:0]         bus_addr,
  output logic [NB_DATA-1:0]         bus_wdata,
  output logic                       bus_wr_en,
  input  logic [NB_DATA-1:0]         bus_rdata,
  output logic                       busy
`ifdef DEBUG_ARB_WPROT_EN
  ,output logic [N_REQ-1:0]          rsp_err
`endif
);
  localparam int IDXW = $clog2(N_REQ);

  arb_state_e state, state_nxt;

  logic [N_REQ-1:0][NB_ADDR-1:0] addr_arr;
  logic [N_REQ-1:0][NB_DATA-1:0] wdata_arr;
  logic [N_REQ-1:0]              grant, gnt_q;
  logic [IDXW-1:0]               pick_idx, ptr_q;
  logic                          any_req;
  logic [NB_ADDR-1:0]            addr_q;
  logic [NB_DATA-1:0]            wdata_q;
  logic                          we_q;
  logic                          wr_block;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  debug_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef DEBUG_ARB_WPROT_EN
  assign wr_block = we_q && !gnt_q[0] && in_wprot(int'(addr_q));
`else
  assign wr_block = 1'b0;
`endif

  // Bus is driven only in ISSUE; derived from state so reset clears it at once.
  assign bus_addr  = (state == ST_ISSUE) ? addr_q  : '0;
  assign bus_wdata = (state == ST_ISSUE) ? wdata_q : '0;
  assign bus_wr_en = (state == ST_ISSUE) && we_q && !wr_block;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rsp_ack   <= '0;
      rsp_rdata <= '0;
`ifdef DEBUG_ARB_WPROT_EN
      rsp_err   <= '0;
`endif
    end else begin
      rsp_ack <= '0;
`ifdef DEBUG_ARB_WPROT_EN
      rsp_err <= '0;
`endif
      if (state == ST_IDLE && any_req) begin
        gnt_q   <= grant;
        addr_q  <= addr_arr[pick_idx];
        wdata_q <= wdata_arr[pick_idx];
        we_q    <= req_we[pick_idx];
        ptr_q   <= (pick_idx == IDXW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      // Read data is captured for writes too, returning the pre-write value.
      if (state == ST_ISSUE) begin
        rsp_rdata <= bus_rdata;
        rsp_ack   <= gnt_q;
`ifdef DEBUG_ARB_WPROT_EN
        rsp_err   <= wr_block ? gnt_q : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter with a small register-file model on the bus.
// Covers the write-protect path when DEBUG_ARB_WPROT_EN is defined.
module tb_debug_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_ack;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_wr_en;
  logic [DW-1:0]   bus_rdata;
  logic            busy;
`ifdef DEBUG_ARB_WPROT_EN
  logic [N-1:0]    rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_bus_arbiter #(.N_REQ(N), .NB_ADDR(AW), .NB_DATA(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_ack   (rsp_ack),
    .rsp_rdata (rsp_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr_en (bus_wr_en),
    .bus_rdata (bus_rdata),
    .busy      (busy)
`ifdef DEBUG_ARB_WPROT_EN
    ,.rsp_err  (rsp_err)
`endif
  );

  // Register file: reloaded during reset, mem[a] = a ^ 0xA5 except mem[0x20] = 0x5A.
  logic [DW-1:0] mem [128];
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem[32] <= 8'h5A;
    end else if (bus_wr_en) begin
      mem[bus_addr] <= bus_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_we[idx]             = we;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
  task automatic do_txn(input string nm, input int idx, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input logic exp_wr,
                        input logic exp_err);
    set_req(idx, we, a, d);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    chk({nm, " issue busy"},  32'(busy), 32'd1);
    chk({nm, " issue addr"},  32'(bus_addr), 32'(a));
    chk({nm, " issue wr_en"}, 32'(bus_wr_en), 32'(exp_wr));
    if (exp_wr) chk({nm, " issue wdata"}, 32'(bus_wdata), 32'(d));
    chk({nm, " issue ack"},   32'(rsp_ack), 32'd0);
    @(negedge clk);
    chk({nm, " ack"},         32'(rsp_ack), 32'(1 << idx));
    chk({nm, " rdata"},       32'(rsp_rdata), 32'(exp_rd));
    chk({nm, " ack wr_en"},   32'(bus_wr_en), 32'd0);
    chk({nm, " ack addr"},    32'(bus_addr), 32'd0);
`ifdef DEBUG_ARB_WPROT_EN
    chk({nm, " err"},         32'(rsp_err), exp_err ? 32'(1 << idx) : 32'd0);
`else
    if (exp_err) chk({nm, " err unsupported"}, 32'd1, 32'd0);
`endif
    req_valid = '0;
    @(negedge clk);
    chk({nm, " idle ack"},    32'(rsp_ack), 32'd0);
    chk({nm, " idle busy"},   32'(busy), 32'd0);
  endtask

  typedef struct {
    int             idx;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    tbl[0] = '{0, 1'b0, 7'h20, 8'h00, 8'h5A};
    tbl[1] = '{1, 1'b1, 7'h30, 8'hC3, 8'h95};
    tbl[2] = '{0, 1'b0, 7'h30, 8'h00, 8'hC3};
    tbl[3] = '{1, 1'b0, 7'h20, 8'h00, 8'h5A};
    tbl[4] = '{0, 1'b1, 7'h7F, 8'h11, 8'hDA};
    tbl[5] = '{1, 1'b0, 7'h7F, 8'h00, 8'h11};
    tbl[6] = '{0, 1'b1, 7'h00, 8'hEE, 8'hA5};
    tbl[7] = '{1, 1'b0, 7'h00, 8'h00, 8'hEE};

    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset ack",   32'(rsp_ack), 32'd0);
    chk("reset rdata", 32'(rsp_rdata), 32'd0);
    chk("reset addr",  32'(bus_addr), 32'd0);
    chk("reset wdata", 32'(bus_wdata), 32'd0);
    chk("reset wr_en", 32'(bus_wr_en), 32'd0);
    chk("reset busy",  32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      do_txn($sformatf("vec%0d", i), tbl[i].idx, tbl[i].we, tbl[i].addr,
             tbl[i].wdata, tbl[i].exp_rd, tbl[i].we, 1'b0);

    // Reset during ISSUE of a requester-0 write (the pointer has already moved to 1).
    set_req(0, 1'b1, 7'h40, 8'h77);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst issue wr_en", 32'(bus_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async wr_en", 32'(bus_wr_en), 32'd0);
    chk("rst async busy",  32'(busy), 32'd0);
    chk("rst async addr",  32'(bus_addr), 32'd0);
    chk("rst async rdata", 32'(rsp_rdata), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst after ack c%0d", c), 32'(rsp_ack), 32'd0);
      chk($sformatf("rst after busy c%0d", c), 32'(busy), 32'd0);
    end

    // Contention after reset: pointer must be 0, so order is 0,1,0,1 every 3 cycles.
    set_req(0, 1'b0, 7'h20, 8'h00);
    set_req(1, 1'b0, 7'h30, 8'h00);
    req_valid = 2'b11;
    n = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (rsp_ack != '0) begin
        if (n < 4) begin
          chk($sformatf("cont ack%0d", n),   32'(rsp_ack), (n % 2 == 0) ? 32'd1 : 32'd2);
          chk($sformatf("cont cyc%0d", n),   32'(c), 32'(2 + 3 * n));
          chk($sformatf("cont rdata%0d", n), 32'(rsp_rdata), (n % 2 == 0) ? 32'h5A : 32'h95);
        end
        n++;
        if (n == 4) req_valid = '0;
      end
    end
    chk("cont ack count", 32'(n), 32'd4);

    // Requester 1 appears during ISSUE and withdraws in ACK: never granted.
    set_req(0, 1'b0, 7'h20, 8'h00);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("wd ack", 32'(rsp_ack), 32'd1);
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("wd no ack c%0d", c),  32'(rsp_ack), 32'd0);
      chk($sformatf("wd no busy c%0d", c), 32'(busy), 32'd0);
    end

`ifdef DEBUG_ARB_WPROT_EN
    do_txn("wprot r1", 1, 1'b1, 7'h10, 8'h01, 8'hB5, 1'b0, 1'b1);
    do_txn("wprot r0", 0, 1'b1, 7'h10, 8'h01, 8'hB5, 1'b1, 1'b0);
    do_txn("wprot rb", 1, 1'b0, 7'h10, 8'h00, 8'h01, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_bus_arbiter.md
Name: debug_bus_arbiter

Overview:
- Shares the single debug register port (address, write data, write enable, combinational read data) among N_REQ requesters. Typical requesters are the SPI slave, an on-chip snapshot engine and a self-test sequencer.
- Sequences each access as one registered bus transaction, using round-robin arbitration and a per-requester valid/ack handshake.
- Sits between the requester blocks and the debug register file.

Parameters:
- N_REQ, 2, number of requesters (2..8); index 0 is the SPI slave.
- NB_ADDR, 7, register address width.
- NB_DATA, 8, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester access request; held with its fields until the matching rsp_ack
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*NB_ADDR  flattened addresses; requester i at bits [i*NB_ADDR +: NB_ADDR]
- req_wdata  in  N_REQ*NB_DATA  flattened write data; same packing as req_addr
- rsp_ack  out  N_REQ  one-hot, 1-cycle completion pulse
- rsp_rdata  out  NB_DATA  read data; valid only while rsp_ack is nonzero
- bus_addr  out  NB_ADDR  register port address
- bus_wdata  out  NB_DATA  register port write data
- bus_wr_en  out  1  register port write strobe
- bus_rdata  in  NB_DATA  register port read data (combinational from bus_addr)
- busy  out  1  high in ISSUE and ACK

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0.
- Bus idle value: when not in ISSUE, bus_addr = 0, bus_wdata = 0, bus_wr_en = 0.
- FSM states: IDLE, ISSUE, ACK. All transitions occur on the clk edge.
- IDLE:
  - If any req_valid is set, pick the winner, register grant_idx and the winner's addr/wdata/we, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - bus_addr and bus_wdata come from the granted requester's registered fields.
  - bus_wr_en = latched we.
  - At the end of the cycle, rsp_rdata <= bus_rdata (also for writes, so a write returns the pre-write register value), rsp_ack[grant_idx] <= 1, then go to ACK.
- ACK (1 cycle):
  - rsp_ack is high for the granted requester only.
  - Next state is IDLE, and rsp_ack clears.
  - Requests are ignored in this cycle; the requester drops or changes req_valid on the following edge.
- Latency: req_valid sampled in IDLE at cycle 0 -> bus driven in cycle 1 -> rsp_ack in cycle 2. Throughput is 1 access per 3 cycles.
- Round-robin arbitration:
  - Search starts at the pointer, wraps modulo N_REQ, and takes the first set req_valid.
  - After a grant, pointer <= (grant_idx+1) mod N_REQ.
  - With N_REQ requesters continuously requesting, each is granted once every N_REQ transactions.
- Simultaneous requests: exactly one grant per transaction; losers keep req_valid high and are never acked early.
- Request withdrawal: dropping req_valid before the grant is legal. Dropping it after the grant has no effect; the transaction completes and is acked.
- Reset mid-operation: immediately return to IDLE; bus_wr_en, rsp_ack, rsp_rdata and busy go to 0. The in-flight transaction is lost and no ack is issued.
- rsp_rdata holds its value after ACK; it is only defined while rsp_ack is nonzero.

Optional Feature:
- Macro DEBUG_ARB_WPROT_EN.
- Defined:
  - Writes from requesters other than index 0 to addresses 0x10..0x1F (control range) are blocked: bus_wr_en stays 0 in ISSUE.
  - The transaction still completes with a normal ack, and rsp_err[grant_idx] pulses together with rsp_ack.
  - Adds port rsp_err  out  N_REQ, reset 0.
- Undefined: all requesters may write any address; there is no rsp_err port.

Decomposition:
- Package debug_arb_pkg holds:
  - FSM state encoding (ST_IDLE, ST_ISSUE, ST_ACK).
  - Protected range constants WPROT_LO = 0x10, WPROT_HI = 0x1F.
  - Default widths.
- One sub-module: debug_rr_arbiter. Combinational round-robin pick: req vector + pointer -> one-hot grant + grant_idx + any_req.

Test Plan:
- Single read: N_REQ=2, requester 0 reads 0x20 with bus_rdata = 0x5A. Bus addr = 0x20 in cycle 1; rsp_ack = 2'b01 and rsp_rdata = 0x5A in cycle 2; bus_wr_en never high.
- Single write: requester 1 writes 0xC3 to 0x30. bus_wr_en high exactly 1 cycle with addr 0x30 and wdata 0xC3; rsp_ack = 2'b10 two cycles after the request.
- Contention: both requesters raise req_valid at once and hold it through their own acks. Grant order 0, 1, 0, 1 across four transactions; ack spacing is 3 cycles.
- Reset in ISSUE: assert rst_n low during the ISSUE cycle of a write. bus_wr_en drops asynchronously, no rsp_ack, state IDLE, and the pointer is 0 after release.
- Withdraw: requester 1 raises req_valid while a transaction is in flight and drops it before the arbiter returns to IDLE. No grant and no ack ever for requester 1.
- WPROT (macro defined): requester 1 writes 0x01 to 0x10. bus_wr_en stays 0; rsp_ack = rsp_err = 2'b10. The same write from requester 0 produces bus_wr_en = 1 and rsp_err = 0.
